// File: rtl/demux3_stream_if.sv
// demux3_stream_if: handshake and data bundle for the 1-to-3 stream demux.
// slave modport is the demux side, master modport is the producer/consumer side.
interface demux3_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic [1:0]       s;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic             v0;
  logic             v1;
  logic             v2;
  logic             r0;
  logic             r1;
  logic             r2;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;
  logic [CNTW-1:0]  cnt2;

  modport slave (
    input  in_valid, d, s, r0, r1, r2,
    output in_ready, y0, y1, y2, v0, v1, v2, cnt0, cnt1, cnt2
  );

  modport master (
    output in_valid, d, s, r0, r1, r2,
    input  in_ready, y0, y1, y2, v0, v1, v2, cnt0, cnt1, cnt2
  );
endinterface

// File: rtl/demux3_stream.sv
// demux3_stream: registered 1-to-3 stream demultiplexer.
// Select encoding matches the 3:1 operand mux: 00 -> lane 0, 01 -> lane 1,
// 1x -> lane 2. Each lane is a one-entry EMPTY/FULL holding register with
// its own valid/ready, so a stalled lane never blocks the other two.
// Optional feature: define DEMUX3_CNT_EN to build the per-lane accepted-word
// counters; otherwise cnt0..cnt2 are tied to zero.
module demux3_stream #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  demux3_stream_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e      state_q [3];
  lane_state_e      state_d [3];
  logic [WIDTH-1:0] y_q     [3];
  logic [WIDTH-1:0] y_d     [3];

  logic [1:0]       sel_s;
  logic [2:0]       v_s;
  logic [2:0]       r_s;
  logic [2:0]       open_s;
  logic [2:0]       load_s;
  logic             in_ready_s;

  assign r_s = {bus.r2, bus.r1, bus.r0};

  // Decode the lane select; both 1x codes map to lane 2.
  always_comb begin
    sel_s = 2'd0;
    case (bus.s)
      2'b00:   sel_s = 2'd0;
      2'b01:   sel_s = 2'd1;
      default: sel_s = 2'd2;
    endcase
  end

  // Lane openness and input ready; depends only on s, lane valid and lane ready.
  always_comb begin
    v_s        = 3'b000;
    open_s     = 3'b000;
    in_ready_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_s[i]    = (state_q[i] == FULL);
      open_s[i] = ~v_s[i] | r_s[i];
    end
    case (sel_s)
      2'd0:    in_ready_s = open_s[0];
      2'd1:    in_ready_s = open_s[1];
      2'd2:    in_ready_s = open_s[2];
      default: in_ready_s = 1'b0;
    endcase
  end

  // Per-lane next state: a load wins over a drain so a same-cycle
  // drain+load replaces the word without a bubble.
  always_comb begin
    load_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      load_s[i]  = bus.in_valid & in_ready_s & (sel_s == 2'(i));
      state_d[i] = state_q[i];
      y_d[i]     = y_q[i];
      if (load_s[i]) begin
        state_d[i] = FULL;
        y_d[i]     = bus.d;
      end else if (v_s[i] & r_s[i]) begin
        state_d[i] = EMPTY;
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Lane state and data registers; reset discards any held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= EMPTY;
        y_q[i]     <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        y_q[i]     <= y_d[i];
      end
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.y0       = y_q[0];
  assign bus.y1       = y_q[1];
  assign bus.y2       = y_q[2];
  assign bus.v0       = v_s[0];
  assign bus.v1       = v_s[1];
  assign bus.v2       = v_s[2];

`ifdef DEMUX3_CNT_EN
  logic [CNTW-1:0] cnt_q [3];
  logic [CNTW-1:0] cnt_d [3];

  // Count accepted words per lane; natural modulo-2^CNTW wrap.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (load_s[i]) begin
        cnt_d[i] = cnt_q[i] + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= {CNTW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
`else
  assign bus.cnt0 = {CNTW{1'b0}};
  assign bus.cnt1 = {CNTW{1'b0}};
  assign bus.cnt2 = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_demux3_stream.sv
// tb_demux3_stream: directed bench with a per-lane scoreboard for demux3_stream.
// Expected counter values follow DEMUX3_CNT_EN (zero when it is undefined).
module tb_demux3_stream;

  localparam int WIDTH = 8;
  localparam int CNTW  = 2;

  logic clk;
  logic reset;

  demux3_stream_if #(.WIDTH(WIDTH), .CNTW(CNTW)) ifc ();

  demux3_stream #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic             m_v   [3];
  logic [WIDTH-1:0] m_y   [3];
  logic [CNTW-1:0]  m_cnt [3];
  logic [WIDTH-1:0] sbq   [3][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] y_of(input int i);
    case (i)
      0:       return ifc.y0;
      1:       return ifc.y1;
      default: return ifc.y2;
    endcase
  endfunction

  function automatic logic v_of(input int i);
    case (i)
      0:       return ifc.v0;
      1:       return ifc.v1;
      default: return ifc.v2;
    endcase
  endfunction

  function automatic logic [CNTW-1:0] cnt_of(input int i);
    case (i)
      0:       return ifc.cnt0;
      1:       return ifc.cnt1;
      default: return ifc.cnt2;
    endcase
  endfunction

  function automatic logic [CNTW-1:0] exp_cnt(input int i);
`ifdef DEMUX3_CNT_EN
    return m_cnt[i];
`else
    return {CNTW{1'b0}};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_v[i]   = 1'b0;
      m_y[i]   = '0;
      m_cnt[i] = '0;
      sbq[i].delete();
    end
  endtask

  task automatic check_lanes(input string ph);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_v%0d", ph, i), 32'(v_of(i)), 32'(m_v[i]));
      check($sformatf("%s_y%0d", ph, i), 32'(y_of(i)), 32'(m_y[i]));
      check($sformatf("%s_cnt%0d", ph, i), 32'(cnt_of(i)), 32'(exp_cnt(i)));
    end
  endtask

  // One clock cycle with current inputs: check in_ready, score drains,
  // update the model, then check registered outputs after the edge.
  task automatic cycle(input string ph);
    int          ln;
    logic        rdy;
    logic [2:0]  rr;
    logic [WIDTH-1:0] exp_w;
    #2;
    rr  = {ifc.r2, ifc.r1, ifc.r0};
    ln  = ifc.s[1] ? 2 : int'(ifc.s[0]);
    rdy = !m_v[ln] || rr[ln];
    check({ph, "_in_ready"}, 32'(ifc.in_ready), 32'(rdy));
    for (int i = 0; i < 3; i++) begin
      if (m_v[i] && rr[i]) begin
        if (sbq[i].size() == 0) begin
          check($sformatf("%s_sb_empty%0d", ph, i), 32'(1), 32'(0));
        end else begin
          exp_w = sbq[i].pop_front();
          check($sformatf("%s_sb_y%0d", ph, i), 32'(y_of(i)), 32'(exp_w));
        end
        m_v[i] = 1'b0;
      end
    end
    if (ifc.in_valid && rdy) begin
      m_v[ln]   = 1'b1;
      m_y[ln]   = ifc.d;
      m_cnt[ln] = m_cnt[ln] + 2'd1;
      sbq[ln].push_back(ifc.d);
    end
    @(posedge clk);
    #1;
    check_lanes(ph);
  endtask

  task automatic send(input logic [WIDTH-1:0] dv, input logic [1:0] sv, input string ph);
    ifc.in_valid = 1'b1;
    ifc.d        = dv;
    ifc.s        = sv;
    cycle(ph);
  endtask

  logic [CNTW-1:0] wrap_seq [5];
  logic [WIDTH-1:0] route_d [4];
  logic [1:0]       route_s [4];

  initial begin
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    route_d  = '{8'h11, 8'h22, 8'h33, 8'h44};
    route_s  = '{2'b00, 2'b01, 2'b10, 2'b11};

    reset        = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.d        = 8'h00;
    ifc.s        = 2'b00;
    ifc.r0       = 1'b0;
    ifc.r1       = 1'b0;
    ifc.r2       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_lanes("rst");
    check("rst_in_ready", 32'(ifc.in_ready), 32'(1));

    // routing, all consumers ready
    ifc.r0 = 1'b1; ifc.r1 = 1'b1; ifc.r2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(route_d[k], route_s[k], $sformatf("route%0d", k));
    end
    ifc.in_valid = 1'b0;
    cycle("route_idle");

    // backpressure on lane 0
    ifc.r0 = 1'b0;
    send(8'hA5, 2'b00, "bp_load");
    send(8'h5A, 2'b00, "bp_stall0");
    cycle("bp_stall1");
    check("bp_y0_hold", 32'(ifc.y0), 32'(8'hA5));
    ifc.r0 = 1'b1;
    cycle("bp_accept");
    ifc.in_valid = 1'b0;
    ifc.r0 = 1'b0;
    cycle("bp_after");
    check("bp_y0_new", 32'(ifc.y0), 32'(8'h5A));
    check("bp_v0_kept", 32'(ifc.v0), 32'(1));

    // lane independence: lane 0 stays blocked and full
    ifc.r1 = 1'b1;
    send(8'h77, 2'b01, "indep");
    check("indep_y1", 32'(ifc.y1), 32'(8'h77));
    check("indep_y0", 32'(ifc.y0), 32'(8'h5A));

    // reset mid-cycle with lane 1 full
    ifc.r1 = 1'b0;
    send(8'h66, 2'b01, "prerst");
    ifc.in_valid = 1'b1;
    ifc.d        = 8'h99;
    ifc.s        = 2'b01;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_lanes("async_rst");
    check("async_rst_in_ready", 32'(ifc.in_ready), 32'(1));
    @(posedge clk);
    #1;
    check_lanes("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // counter wrap on lane 2
    ifc.r2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(8'(8'hC0 + k), 2'b10, $sformatf("wrap%0d", k));
`ifdef DEMUX3_CNT_EN
      check($sformatf("wrap_seq%0d", k), 32'(ifc.cnt2), 32'(wrap_seq[k]));
`else
      check($sformatf("wrap_off%0d", k), 32'(ifc.cnt2), 32'(0));
`endif
    end

    // drain everything
    ifc.in_valid = 1'b0;
    ifc.r0 = 1'b1; ifc.r1 = 1'b1; ifc.r2 = 1'b1;
    cycle("drain0");
    cycle("drain1");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sb_left%0d", i), 32'(sbq[i].size()), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
